eth_rx_buf_mgr: RTL



---
 rtl/eth_rx_buf_mgr_pkg.sv | 26 ++
 rtl/eth_rx_buf_mgr_if.sv | 16 +
 rtl/eth_rx_buf_mgr_addr_match.sv | 23 ++
 rtl/eth_rx_buf_mgr.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_buf_mgr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_pkg
//  Brief    : Shared types and constants for the Ethernet receive buffer
//             manager (state encoding, address-filter constants).
//  Revision : 1.0 - initial release
// ============================================================================
package eth_rx_pkg;

   // Frame-handling state of the receive buffer manager
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      DROP  = 2'd2,
      CHECK = 2'd3
   } rx_state_t;

   // IPv4 multicast OUI prefix (01:00:5E)
   localparam logic [23:0] MCAST_PREFIX = 24'h01005E;
   // Broadcast destination
   localparam logic [47:0] BCAST        = 48'hFFFF_FFFF_FFFF;
   // Frames shorter than a destination address are runts
   localparam int          MIN_HDR      = 6;

endpackage : eth_rx_pkg
`default_nettype wire

// File: rtl/eth_rx_buf_mgr_if.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_buf_mgr_if
//  Brief    : 8-bit AXI-Stream receive bus from the MAC (no backpressure).
//  Revision : 1.0 - initial release
// ============================================================================
interface eth_rx_buf_mgr_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tlast;
   logic       tuser;

   modport master (output tdata, output tvalid, output tlast, output tuser);
   modport slave  (input  tdata, input  tvalid, input  tlast, input  tuser);
endinterface : eth_rx_buf_mgr_if
`default_nettype wire

// File: rtl/eth_rx_buf_mgr_addr_match.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_addr_match
//  Brief    : Combinational destination-MAC filter: multicast, broadcast,
//             station address or promiscuous mode.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_rx_addr_match
   import eth_rx_pkg::*;
(
   input  wire logic [47:0] i_dest_mac,
   input  wire logic [47:0] i_mac_address,
   input  wire logic        i_promiscuous,
   output logic             o_match
);

   assign o_match = (i_dest_mac[47:24] == MCAST_PREFIX) |
                    (i_dest_mac == BCAST)               |
                    (i_dest_mac == i_mac_address)       |
                    i_promiscuous;

endmodule : eth_rx_addr_match
`default_nettype wire

// File: rtl/eth_rx_buf_mgr.sv
`default_nettype none
// ============================================================================
//  Module   : eth_rx_buf_mgr
//  Brief    : Receive buffer manager. Streams MAC bytes into an NBUF-slot
//             packet-RAM ring, filters frames, commits accepted lengths and
//             advances the hardware produce pointer.
//  Revision : 1.0 - initial release
// ============================================================================
module eth_rx_buf_mgr
   import eth_rx_pkg::*;
#(
   parameter int NBUF   = 8,
   parameter int ADDR_W = 11,
   parameter int PTR_W  = $clog2(NBUF) + 1
)(
   input  wire logic                      rx_clk,
   input  wire logic                      rx_rst_n,
   eth_rx_buf_mgr_if.slave                rx_axis,
   input  wire logic                      rx_error_bad_fcs,
   input  wire logic                      rx_error_bad_frame,
   input  wire logic [47:0]               mac_address,
   input  wire logic                      promiscuous,
   input  wire logic                      cooked,
   input  wire logic                      irq_en,
   input  wire logic [PTR_W-1:0]          firstbuf,
   output logic                           buf_we,
   output logic [PTR_W-1+ADDR_W-1:0]      buf_addr,
   output logic [7:0]                     buf_wdata,
   output logic [PTR_W-1:0]               nextbuf,
   output logic                           avail,
   output logic                           eth_irq,
   input  wire logic [PTR_W-2:0]          len_rd_idx,
   output logic [ADDR_W:0]                len_rd_data,
   output logic [31:0]                    fcs_err_cnt,
   output logic [31:0]                    frame_err_cnt,
   output logic [31:0]                    ovf_cnt
);

   localparam int               SLOT_W    = PTR_W - 1;
   localparam logic [ADDR_W:0]  C_MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [PTR_W-1:0] C_NBUF    = PTR_W'(NBUF);
   localparam logic [ADDR_W:0]  C_MIN_HDR = (ADDR_W+1)'(MIN_HDR);

   rx_state_t                   r_state;
   logic [ADDR_W:0]             r_byte_cnt;
   logic [47:0]                 r_dest_mac;
   logic [PTR_W-1:0]            r_nextbuf;
   logic                        r_tuser_seen;
   logic                        r_fcs_seen;
   logic                        r_frm_seen;
   logic                        r_oversize;
   logic                        r_buf_we;
   logic [SLOT_W+ADDR_W-1:0]    r_buf_addr;
   logic [7:0]                  r_buf_wdata;
   logic                        r_avail;
   logic                        r_irq;
   logic [31:0]                 r_fcs_cnt;
   logic [31:0]                 r_frm_cnt;
   logic [31:0]                 r_ovf_cnt;
   logic [ADDR_W:0]             r_len [NBUF];

   logic                        w_full;
   logic                        w_match;
   logic                        w_runt;
   logic                        w_err_fcs;
   logic                        w_err_frm;
   logic                        w_accept;
   logic                        w_avail;
   logic [SLOT_W-1:0]           w_slot;

   assign w_slot    = r_nextbuf[SLOT_W-1:0];
   // Occupancy is computed modulo the pointer range; the spare MSB makes full distinct from empty
   assign w_full    = ((r_nextbuf - firstbuf) == C_NBUF);
   assign w_runt    = (r_byte_cnt < C_MIN_HDR);
   // Error pulses may land on the tlast cycle (latched) or on the CHECK cycle itself
   assign w_err_fcs = r_fcs_seen | rx_error_bad_fcs;
   assign w_err_frm = r_frm_seen | rx_error_bad_frame | r_tuser_seen | w_runt;
   assign w_accept  = w_match & (~(w_err_fcs | w_err_frm) | cooked) & ~w_runt;
   assign w_avail   = (r_nextbuf != firstbuf);

   eth_rx_addr_match u_addr_match (
      .i_dest_mac    (r_dest_mac),
      .i_mac_address (mac_address),
      .i_promiscuous (promiscuous),
      .o_match       (w_match)
   );

   // Frame FSM: slot write path, header capture, error accounting and commit
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         r_state      <= IDLE;
         r_byte_cnt   <= '0;
         r_dest_mac   <= '0;
         r_nextbuf    <= '0;
         r_tuser_seen <= 1'b0;
         r_fcs_seen   <= 1'b0;
         r_frm_seen   <= 1'b0;
         r_oversize   <= 1'b0;
         r_buf_we     <= 1'b0;
         r_buf_addr   <= '0;
         r_buf_wdata  <= '0;
         r_fcs_cnt    <= '0;
         r_frm_cnt    <= '0;
         r_ovf_cnt    <= '0;
         for (int i = 0; i < NBUF; i++) r_len[i] <= '0;
      end else begin
         r_buf_we <= 1'b0;
         case (r_state)
            IDLE: begin
               if (rx_axis.tvalid) begin
                  if (w_full) begin
                     r_ovf_cnt  <= r_ovf_cnt + 32'd1;
                     r_oversize <= 1'b0;
                     if (!rx_axis.tlast) r_state <= DROP;
                  end else begin
                     r_buf_we     <= 1'b1;
                     r_buf_addr   <= {w_slot, {ADDR_W{1'b0}}};
                     r_buf_wdata  <= rx_axis.tdata;
                     r_byte_cnt   <= (ADDR_W+1)'(1);
                     r_dest_mac   <= {r_dest_mac[39:0], rx_axis.tdata};
                     r_tuser_seen <= rx_axis.tlast & rx_axis.tuser;
                     r_fcs_seen   <= rx_axis.tlast & rx_error_bad_fcs;
                     r_frm_seen   <= rx_axis.tlast & rx_error_bad_frame;
                     r_state      <= rx_axis.tlast ? CHECK : RECV;
                  end
               end
            end
            RECV: begin
               if (rx_axis.tvalid) begin
                  if (r_byte_cnt == C_MAX_LEN) begin
                     // Slot is full: the frame can never be committed
                     if (rx_axis.tlast) begin
                        r_frm_cnt <= r_frm_cnt + 32'd1;
                        r_state   <= IDLE;
                     end else begin
                        r_oversize <= 1'b1;
                        r_state    <= DROP;
                     end
                  end else begin
                     r_buf_we     <= 1'b1;
                     r_buf_addr   <= {w_slot, r_byte_cnt[ADDR_W-1:0]};
                     r_buf_wdata  <= rx_axis.tdata;
                     r_byte_cnt   <= r_byte_cnt + (ADDR_W+1)'(1);
                     if (r_byte_cnt < C_MIN_HDR)
                        r_dest_mac <= {r_dest_mac[39:0], rx_axis.tdata};
                     r_tuser_seen <= rx_axis.tlast & rx_axis.tuser;
                     r_fcs_seen   <= rx_axis.tlast & rx_error_bad_fcs;
                     r_frm_seen   <= rx_axis.tlast & rx_error_bad_frame;
                     if (rx_axis.tlast) r_state <= CHECK;
                  end
               end
            end
            DROP: begin
               if (rx_axis.tvalid && rx_axis.tlast) begin
                  if (r_oversize) r_frm_cnt <= r_frm_cnt + 32'd1;
                  r_oversize <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            CHECK: begin
               if (rx_axis.tvalid) begin
                  // Beat with no gap after tlast: discard the frame and the new beat
                  r_frm_cnt  <= r_frm_cnt + 32'd1;
                  r_oversize <= 1'b0;
                  r_state    <= rx_axis.tlast ? IDLE : DROP;
               end else begin
                  if (w_err_fcs) r_fcs_cnt <= r_fcs_cnt + 32'd1;
                  if (w_err_frm) r_frm_cnt <= r_frm_cnt + 32'd1;
                  if (w_accept) begin
                     r_len[w_slot] <= r_byte_cnt;
                     r_nextbuf     <= r_nextbuf + PTR_W'(1);
                  end
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Status flags registered from the live pointers so software sees clean levels
   always_ff @(posedge rx_clk or negedge rx_rst_n) begin
      if (!rx_rst_n) begin
         r_avail <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_avail <= w_avail;
         r_irq   <= w_avail & irq_en;
      end
   end

   assign buf_we        = r_buf_we;
   assign buf_addr      = r_buf_addr;
   assign buf_wdata     = r_buf_wdata;
   assign nextbuf       = r_nextbuf;
   assign avail         = r_avail;
   assign eth_irq       = r_irq;
   assign len_rd_data   = r_len[len_rd_idx];
   assign fcs_err_cnt   = r_fcs_cnt;
   assign frame_err_cnt = r_frm_cnt;
   assign ovf_cnt       = r_ovf_cnt;

endmodule : eth_rx_buf_mgr
`default_nettype wire
